imm_encode: RTL and testbench

- Encoder counterpart of the immediate generator: packs a 32-bit signed immediate into the immediate bit-fields of a base RV32I instruction word.
- Selects the format with an `imm_e` value from `definitions_pkg`.
- Checks that the immediate is representable (range and alignment) and returns the patched instruction.
- Two-stage valid/ready pipeline; used by the instruction-patching/self-test path feeding instruction memory.

---
 rtl/imm_encode.sv | 149 ++++++++++++++
 tb/tb_imm_encode.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imm_encode.sv
// Packs a signed immediate into the immediate fields of an RV32I instruction word.
// The result is checked for range and alignment, and a two-stage valid/ready pipeline returns it.
package definitions_pkg;
  typedef enum logic [2:0] {
    IMM_I_TYPE = 3'd0,
    IMM_STORE  = 3'd1,
    IMM_BRANCH = 3'd2,
    IMM_JAL    = 3'd3,
    IMM_U_TYPE = 3'd4
  } imm_e;
endpackage

module imm_encode #(
  parameter bit CHECK_ALIGN = 1'b1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  definitions_pkg::imm_e    imm_sel,
  input  logic [31:0]              base_inst,
  input  logic [31:0]              imm_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic                     out_range_err,
  output logic                     out_misalign,
  output logic [ERR_CNT_W-1:0]     err_count
);
  import definitions_pkg::*;

  // True when v is the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic signed [31:0] v, input int bits);
    logic signed [31:0] top;
    top = v >>> (bits - 1);
    return (top == 32'sd0) || (top == -32'sd1);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic signed [31:0] imm_s;
  logic [31:0]        mask;
  logic [31:0]        field;
  logic               rng_err;
  logic               mis_err;
  logic [31:0]        base_masked;
  logic [31:0]        field_masked;

  assign imm_s = imm_value;

  always_comb begin
    mask    = '0;
    field   = '0;
    rng_err = 1'b0;
    mis_err = 1'b0;
    case (imm_sel)
      IMM_I_TYPE: begin
        mask    = 32'hFFF0_0000;
        field   = {imm_value[11:0], 20'b0};
        rng_err = !fits_signed(imm_s, 12);
      end
      IMM_STORE: begin
        mask    = 32'hFE00_0F80;
        field   = {imm_value[11:5], 13'b0, imm_value[4:0], 7'b0};
        rng_err = !fits_signed(imm_s, 12);
      end
      IMM_BRANCH: begin
        mask    = 32'hFE00_0F80;
        field   = {imm_value[12], imm_value[10:5], 13'b0, imm_value[4:1], imm_value[11], 7'b0};
        rng_err = !fits_signed(imm_s, 13);
        mis_err = CHECK_ALIGN && imm_value[0];
      end
      IMM_JAL: begin
        mask    = 32'hFFFF_F000;
        field   = {imm_value[20], imm_value[10:1], imm_value[11], imm_value[19:12], 12'b0};
        rng_err = !fits_signed(imm_s, 21);
        mis_err = CHECK_ALIGN && imm_value[0];
      end
      IMM_U_TYPE: begin
        mask    = 32'hFFFF_F000;
        field   = {imm_value[31:12], 12'b0};
        mis_err = |imm_value[11:0];
      end
      default: rng_err = 1'b1;
    endcase
  end

  // A flagged request passes base_inst through untouched, so the field is zeroed here.
  assign base_masked  = (rng_err || mis_err) ? base_inst : (base_inst & ~mask);
  assign field_masked = (rng_err || mis_err) ? 32'h0 : field;

  logic        vld_p1;
  logic [31:0] base_p1;
  logic [31:0] field_p1;
  logic        rng_p1;
  logic        mis_p1;
  logic        s1_load;
  logic        s2_load;

  assign s2_load   = vld_p1 && (!out_valid || out_ready);
  assign in_ready  = !vld_p1 || s2_load;
  assign s1_load   = in_valid && in_ready;

  // ---- stage 1: checks, masked base, packed field ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      base_p1  <= base_masked;
      field_p1 <= field_masked;
      rng_p1   <= rng_err;
      mis_p1   <= mis_err;
    end
  end

  // ---- stage 2: merge, output registers, error counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_inst      <= '0;
      out_range_err <= 1'b0;
      out_misalign  <= 1'b0;
      err_count     <= '0;
    end else begin
      if (out_valid && out_ready && (out_range_err || out_misalign))
        err_count <= sat_inc(err_count);
      if (s2_load) begin
        out_valid     <= 1'b1;
        out_inst      <= base_p1 | field_p1;
        out_range_err <= rng_p1;
        out_misalign  <= mis_p1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Directed-vector bench for imm_encode: encodings, error flags, saturation, backpressure and reset.
module tb_imm_encode;
  import definitions_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  imm_e          imm_sel;
  logic [31:0]   base_inst;
  logic [31:0]   imm_value;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic          out_range_err;
  logic          out_misalign;
  logic [CW-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  imm_encode #(.CHECK_ALIGN(1'b1), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .base_inst(base_inst), .imm_value(imm_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_range_err(out_range_err), .out_misalign(out_misalign), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One isolated request with out_ready high; the counter is checked after the hand-off edge.
  task automatic run_one(input string tag, input logic [2:0] sel, input logic [31:0] base,
                         input logic [31:0] imm, input logic [31:0] exp_inst,
                         input logic exp_rng, input logic exp_mis, input logic [31:0] exp_cnt);
    @(negedge clk);
    in_valid  = 1'b1;
    imm_sel   = imm_e'(sel);
    base_inst = base;
    imm_value = imm;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_vld_early"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_rng"}, {31'b0, out_range_err}, {31'b0, exp_rng});
    check({tag, "_mis"}, {31'b0, out_misalign}, {31'b0, exp_mis});
    @(posedge clk); #1;
    check({tag, "_cnt"}, 32'(err_count), exp_cnt);
  endtask

  logic [31:0] exp_q [4];
  int          idx;
  int          nout;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    imm_sel   = IMM_I_TYPE;
    base_inst = '0;
    imm_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_flags", {30'b0, out_range_err, out_misalign}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_one("i_neg1",  3'd0, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b0, 32'd0);
    run_one("store8",  3'd1, 32'h0020_A023, 32'h0000_0008, 32'h0020_A423, 1'b0, 1'b0, 32'd0);
    run_one("br_m4",   3'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0, 32'd0);
    run_one("jal8",    3'd3, 32'h0000_006F, 32'h0000_0008, 32'h0080_006F, 1'b0, 1'b0, 32'd0);
    run_one("jal_neg", 3'd3, 32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 1'b0, 1'b0, 32'd0);
    run_one("u_ok",    3'd4, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0, 1'b0, 32'd0);
    run_one("i_2047",  3'd0, 32'h0000_0093, 32'h0000_07FF, 32'h7FF0_0093, 1'b0, 1'b0, 32'd0);
    run_one("i_2048",  3'd0, 32'h0000_0093, 32'h0000_0800, 32'h0000_0093, 1'b1, 1'b0, 32'd1);
    run_one("br_odd",  3'd2, 32'h0000_0063, 32'h0000_0003, 32'h0000_0063, 1'b0, 1'b1, 32'd2);
    run_one("u_low",   3'd4, 32'h0000_0037, 32'h1234_5001, 32'h0000_0037, 1'b0, 1'b1, 32'd3);
    run_one("jal_rng", 3'd3, 32'h0000_006F, 32'h0010_0000, 32'h0000_006F, 1'b1, 1'b0, 32'd3);
    run_one("bad_sel", 3'd5, 32'h0000_0013, 32'h0000_0004, 32'h0000_0013, 1'b1, 1'b0, 32'd3);

    // Backpressure: out_ready low for the first 6 cycles while 4 items stream in.
    for (int k = 0; k < 4; k++) exp_q[k] = ((k + 1) << 20) | 32'h13;
    idx  = 0;
    nout = 0;
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      logic acc;
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (idx < 4);
      imm_sel   = IMM_I_TYPE;
      base_inst = 32'h13;
      imm_value = idx + 1;
      #1;
      acc = in_valid && in_ready;
      if (cyc == 5) begin
        check("bp_accepts", idx, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (out_valid && !out_ready)
        check("bp_hold", out_inst, exp_q[0]);
      if (out_valid && out_ready) begin
        check("bp_order", out_inst, exp_q[nout]);
        nout++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_out_total", nout, 32'd4);
    check("bp_in_total", idx, 32'd4);

    // Reset asserted while a result is held at the output.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_sel   = IMM_I_TYPE;
    imm_value = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_vld_before", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'b0, out_valid}, 32'd0);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    check("mid_rst_inst", out_inst, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);
    run_one("post_rst", 3'd1, 32'h0000_0023, 32'hFFFF_FFFF, 32'hFE00_0FA3, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
